// File: rtl/lsu_mem_ctrl.sv
// Load/store unit bridging the control unit's memory requests to a single-port
// word-addressed data SRAM. Sub-word stores are done as read-modify-write.
module lsu_mem_ctrl #(
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              busy,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned DW = 32;
    localparam logic [DW:0] ADDR_LIMIT = (DW+1)'(4) << MEM_AW;

    // The RDW state assumes read data arrives exactly one cycle after the strobe
    if (RD_LAT != 1) begin : g_bad_rd_lat
        $fatal(1, "lsu_mem_ctrl: only RD_LAT == 1 is supported");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RDW  = 3'd2,
        S_WR   = 3'd3,
        S_RSP  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [1:0]    off_q;
    logic [DW-1:0] wdata_q;

    logic          accept_c;
    logic          err_c;
    logic [7:0]    lane_b_c;
    logic [15:0]   lane_h_c;
    logic [DW-1:0] load_c;
    logic [DW-1:0] merge_c;

    logic              req_ready_d, resp_valid_d, resp_err_d, busy_d;
    logic              mem_rd_en_d, mem_wr_en_d;
    logic [DW-1:0]     resp_rdata_d, mem_wdata_d;
    logic [MEM_AW-1:0] mem_addr_d;

    assign accept_c = (state == S_IDLE) && req_valid;

    // Reject illegal size, misalignment and out-of-range addresses on the raw request
    assign err_c = (req_size == 2'b11)
                || ((req_size == 2'b01) && req_addr[0])
                || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                || ({1'b0, req_addr} >= ADDR_LIMIT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_valid) begin
                if (err_c)                           state_nxt = S_RSP;
                else if (req_we && req_size == 2'b10) state_nxt = S_WR;
                else                                  state_nxt = S_RD;
            end
            S_RD:    state_nxt = S_RDW;
            S_RDW:   state_nxt = we_q ? S_WR : S_RSP;
            S_WR:    state_nxt = S_RSP;
            S_RSP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture the request at accept; held until the next accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            wdata_q <= '0;
        end else if (accept_c) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
        end
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        lane_b_c = 8'(mem_rdata >> {off_q, 3'b000});
        lane_h_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_c = uns_q ? {24'd0, lane_b_c} : {{24{lane_b_c[7]}}, lane_b_c};
            2'b01:   load_c = uns_q ? {16'd0, lane_h_c} : {{16{lane_h_c[15]}}, lane_h_c};
            default: load_c = mem_rdata;
        endcase
        merge_c = mem_rdata;
        case (size_q)
            2'b00:   merge_c[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (off_q[1]) merge_c[31:16] = wdata_q[15:0];
                else          merge_c[15:0]  = wdata_q[15:0];
            end
            default: merge_c = wdata_q;
        endcase
    end

    // Output decode from the upcoming state so every output is registered
    always_comb begin
        req_ready_d  = (state_nxt == S_IDLE);
        busy_d       = (state_nxt != S_IDLE);
        mem_rd_en_d  = (state_nxt == S_RD);
        mem_wr_en_d  = (state_nxt == S_WR);
        resp_valid_d = (state_nxt == S_RSP);
        resp_err_d   = (state == S_IDLE) && (state_nxt == S_RSP);
        resp_rdata_d = '0;
        mem_wdata_d  = '0;
        mem_addr_d   = mem_addr;
        if (accept_c)
            mem_addr_d = req_addr[MEM_AW+1:2];
        if ((state == S_RDW) && (state_nxt == S_RSP))
            resp_rdata_d = load_c;
        if (state_nxt == S_WR)
            mem_wdata_d = (state == S_IDLE) ? req_wdata : merge_c;
    end

    // Output registers; reset drops every strobe immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_wdata  <= '0;
            mem_addr   <= '0;
        end else begin
            req_ready  <= req_ready_d;
            busy       <= busy_d;
            mem_rd_en  <= mem_rd_en_d;
            mem_wr_en  <= mem_wr_en_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            mem_wdata  <= mem_wdata_d;
            mem_addr   <= mem_addr_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a one-cycle-latency SRAM model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        busy;
    logic [9:0]  mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int passed = 0;

    int rd_cnt = 0;
    int wr_cnt = 0;
    int both_cnt = 0;

    logic [31:0] mem [1024];

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.MEM_AW(10), .RD_LAT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // SRAM model: read data appears one cycle after the strobe is sampled
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // Strobe counters
    always @(posedge clk) begin
        if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (mem_wr_en) wr_cnt <= wr_cnt + 1;
        if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive a request at a negedge; returns at the negedge one cycle after accept
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid    = 1'b0;
    endtask

    // Count cycles after accept until resp_valid, bounded
    task automatic wait_resp(output int lat);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready); else passed++;
        checks++;
        if ({busy, resp_valid, resp_err, mem_rd_en, mem_wr_en} !== 5'b0)
            $display("FAIL reset_ctrl got=%b exp=00000", {busy, resp_valid, resp_err, mem_rd_en, mem_wr_en});
        else passed++;
        checks++;
        if ({resp_rdata, mem_wdata, mem_addr} !== 74'd0)
            $display("FAIL reset_data got=%h exp=0", {resp_rdata, mem_wdata, mem_addr});
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_word();
        int lat;
        int rd0;
        // preload word[1]
        issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h8899AABB);
        wait_resp(lat);
        checks++; if (lat !== 2) $display("FAIL sw_pre_lat got=%0d exp=2", lat); else passed++;
        @(negedge clk);
        rd0 = rd_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
        checks++;
        if ({mem_wr_en, mem_rd_en, mem_addr, mem_wdata} !== {1'b1, 1'b0, 10'd2, 32'hDEADBEEF})
            $display("FAIL sw_write got=wr%b rd%b a%0d d%h exp=wr1 rd0 a2 dDEADBEEF",
                     mem_wr_en, mem_rd_en, mem_addr, mem_wdata);
        else passed++;
        wait_resp(lat);
        checks++; if (lat !== 2) $display("FAIL sw_lat got=%0d exp=2", lat); else passed++;
        checks++; if (resp_err !== 1'b0) $display("FAIL sw_err got=%b exp=0", resp_err); else passed++;
        @(negedge clk);
        checks++; if (rd_cnt - rd0 !== 0) $display("FAIL sw_no_read got=%0d exp=0", rd_cnt - rd0); else passed++;
    endtask

    task automatic test_loads();
        logic [31:0] addrs [4] = '{32'h5, 32'h5, 32'h6, 32'h6};
        logic [1:0]  sizes [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        unss  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps  [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, sizes[i], unss[i], addrs[i], 32'hFFFFFFFF);
            checks++;
            if ({mem_rd_en, req_ready, mem_addr} !== {1'b1, 1'b0, 10'd1})
                $display("FAIL ld%0d_rd got=rd%b rdy%b a%0d exp=rd1 rdy0 a1", i, mem_rd_en, req_ready, mem_addr);
            else passed++;
            wait_resp(lat);
            checks++; if (lat !== 3) $display("FAIL ld%0d_lat got=%0d exp=3", i, lat); else passed++;
            checks++;
            if (resp_rdata !== exps[i]) $display("FAIL ld%0d_data got=%h exp=%h", i, resp_rdata, exps[i]);
            else passed++;
            @(negedge clk);
            checks++;
            if ({resp_valid, resp_rdata} !== 33'd0) $display("FAIL ld%0d_clear got=%b/%h exp=0/0", i, resp_valid, resp_rdata);
            else passed++;
        end
    endtask

    task automatic test_store_byte();
        int lat;
        issue(1'b1, 2'b00, 1'b0, 32'h6, 32'h12345677);
        checks++; if (mem_rd_en !== 1'b1) $display("FAIL sb_rd got=%b exp=1", mem_rd_en); else passed++;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({mem_wr_en, mem_rd_en, mem_wdata} !== {1'b1, 1'b0, 32'h8877AABB})
            $display("FAIL sb_wr got=wr%b rd%b d%h exp=wr1 rd0 d8877AABB", mem_wr_en, mem_rd_en, mem_wdata);
        else passed++;
        wait_resp(lat);
        checks++; if (lat !== 2) $display("FAIL sb_lat got=%0d exp=4", lat + 2); else passed++;
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        wait_resp(lat);
        checks++; if (resp_rdata !== 32'h8877AABB) $display("FAIL sb_readback got=%h exp=8877AABB", resp_rdata); else passed++;
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic        wes   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  sizes [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] addrs [4] = '{32'h3, 32'h2, 32'h0, 32'h1000};
        int rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            issue(wes[i], sizes[i], 1'b0, addrs[i], 32'hA5A5A5A5);
            checks++;
            if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 32'd0})
                $display("FAIL err%0d got=v%b e%b d%h exp=v1 e1 d0", i, resp_valid, resp_err, resp_rdata);
            else passed++;
            @(negedge clk);
        end
        checks++;
        if ((rd_cnt - rd0) + (wr_cnt - wr0) !== 0)
            $display("FAIL err_strobes got=%0d exp=0", (rd_cnt - rd0) + (wr_cnt - wr0));
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic rdy [3];
        int lat;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h4; req_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b1; req_wdata = 32'h11223344;
        rdy[0] = req_ready;
        @(negedge clk);
        rdy[1] = req_ready;
        @(negedge clk);
        rdy[2] = req_ready;
        checks++;
        if ({rdy[0], rdy[1], rdy[2]} !== 3'b000) $display("FAIL b2b_ready_busy got=%b%b%b exp=000", rdy[0], rdy[1], rdy[2]);
        else passed++;
        checks++;
        if ({resp_valid, resp_rdata} !== {1'b1, 32'h8877AABB})
            $display("FAIL b2b_first got=v%b d%h exp=v1 d8877AABB", resp_valid, resp_rdata);
        else passed++;
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid} !== 2'b10) $display("FAIL b2b_idle got=%b exp=10", {req_ready, resp_valid}); else passed++;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({mem_wr_en, req_ready, mem_wdata} !== {2'b10, 32'h11223344})
            $display("FAIL b2b_second got=wr%b rdy%b d%h exp=wr1 rdy0 d11223344", mem_wr_en, req_ready, mem_wdata);
        else passed++;
        wait_resp(lat);
        checks++; if (lat !== 2) $display("FAIL b2b_second_lat got=%0d exp=2", lat); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sb();
        int wr0;
        int lat;
        wr0 = wr_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h5, 32'h000000EE);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, busy, mem_wr_en, mem_rd_en} !== 4'b1000)
            $display("FAIL rst_mid got=%b exp=1000", {req_ready, busy, mem_wr_en, mem_rd_en});
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (wr_cnt - wr0 !== 0) $display("FAIL rst_no_write got=%0d exp=0", wr_cnt - wr0); else passed++;
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        wait_resp(lat);
        checks++; if (resp_rdata !== 32'h11223344) $display("FAIL rst_mem_kept got=%h exp=11223344", resp_rdata); else passed++;
        @(negedge clk);
        checks++; if (both_cnt !== 0) $display("FAIL rd_wr_overlap got=%0d exp=0", both_cnt); else passed++;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_store_word();
        test_loads();
        test_store_byte();
        test_errors();
        test_back_to_back();
        test_reset_mid_sb();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit between the control unit's memory outputs and the single-port data SRAM.
- Takes one load/store request at a time, drives word-addressed SRAM accesses, and returns sign/zero-extended load data.
- Sub-word stores use a read-modify-write (RMW) sequence, because the SRAM has no byte enables.
- Misaligned, out-of-range and illegal-size requests are flagged and never touch memory.

Parameters:
- MEM_AW, 10: SRAM word-address width; the valid byte range is 0 .. (4<<MEM_AW)-1.
- RD_LAT, 1: SRAM read latency in cycles. Only the value 1 is supported; any other value is a fatal elaboration error.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request; high only in IDLE.
- req_we, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned, input, 1: zero-extend on loads (lbu/lhu); ignored for words and stores.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data, taken from the low bits.
- resp_valid, output, 1: one-cycle completion pulse.
- resp_err, output, 1: valid with resp_valid; request was rejected.
- resp_rdata, output, 32: load result; 0 for stores and errors.
- busy, output, 1: high whenever the state is not IDLE.
- mem_addr, output, MEM_AW: SRAM word index, equal to req_addr[MEM_AW+1:2].
- mem_rd_en, output, 1: SRAM read strobe.
- mem_wr_en, output, 1: SRAM write strobe.
- mem_wdata, output, 32: SRAM write data.
- mem_rdata, input, 32: SRAM read data, valid RD_LAT cycles after mem_rd_en is sampled.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0 except req_ready, which is 1.
  - The captured request registers are cleared.
  - If reset hits mid-operation, the operation is abandoned. mem_wr_en drops immediately, so no write is issued after reset asserts.
- Accept: at a rising edge with req_valid && req_ready. At that edge, addr, we, size, unsigned and wdata are captured. Later changes on the req_* inputs are ignored until the block returns to IDLE.
- Error check at accept, evaluated on the raw request. resp_err is set when any of these holds:
  - size == 11;
  - half access with addr[0] == 1;
  - word access with addr[1:0] != 0;
  - addr >= (4<<MEM_AW).
- Error path: IDLE -> RSP, giving resp_valid and resp_err 1 cycle after accept with resp_rdata = 0. No mem_rd_en or mem_wr_en is ever asserted.
- States are IDLE, RD, RDW, WR, RSP. Routes:
  - Load: IDLE -> RD -> RDW -> RSP -> IDLE.
  - Word store: IDLE -> WR -> RSP -> IDLE.
  - Byte/half store: IDLE -> RD -> RDW -> WR -> RSP -> IDLE.
- RD: mem_rd_en = 1 and mem_addr is the captured word index, for exactly one cycle.
- RDW: mem_rdata is valid and is registered on the exit edge.
  - Load extraction uses the byte lane addr[1:0] and the half lane addr[1].
  - Sign extension uses bit 7 or bit 15 of the selected lane unless unsigned is set.
  - Store merge replaces only the addressed lane with the low bits of wdata; all other bytes are kept from mem_rdata.
- WR: mem_wr_en = 1 for exactly one cycle.
  - mem_wdata is the merged word, or wdata for a word store.
  - mem_rd_en is 0 in WR.
- RSP: resp_valid = 1 for exactly one cycle, with no backpressure.
  - req_ready = 0 in RSP.
  - Return to IDLE; a new request can be accepted on the following cycle.
- Latency from the accept edge to resp_valid:
  - load: 3 cycles;
  - word store: 2 cycles;
  - sub-word store: 4 cycles;
  - error: 1 cycle.
- Outputs outside their active states:
  - mem_rd_en, mem_wr_en and resp_valid are 0.
  - resp_rdata and resp_err hold their value only while resp_valid is high; they are 0 otherwise.
  - mem_addr keeps the captured index through the whole operation.
- Never drive mem_rd_en and mem_wr_en high in the same cycle.
- Throughput: at most one outstanding request. With req_valid held high, the next request is accepted in the first IDLE cycle after RSP.

Test Plan:
- Preload word[1] = 0x8899AABB, then load byte (lb) addr 0x5 -> resp_rdata 0xFFFFFFAA at accept+3; lbu addr 0x5 -> 0x000000AA; lh addr 0x6 -> 0xFFFF8899; lhu addr 0x6 -> 0x00008899.
- Store byte (sb) addr 0x6, wdata 0x12345677 -> RD, then WR with mem_wdata 0x8877AABB; resp_valid at accept+4; a following lw 0x4 returns 0x8877AABB.
- Store word (sw) addr 0x8, wdata 0xDEADBEEF -> no mem_rd_en; mem_wr_en at accept+1 with mem_addr 2; resp_valid at accept+2.
- Errors: sh 0x3, lw 0x2, size 11, and lw 0x1000 (MEM_AW = 10) -> resp_err = 1 at accept+1; mem_rd_en and mem_wr_en stay 0 throughout.
- Back-to-back: req_valid held for lw 0x4 then sw 0x4 -> second accept occurs exactly one cycle after the first resp_valid; req_ready = 0 during RD, RDW, RSP.
- Reset mid-sb: assert rst low during RDW -> next sample shows IDLE, req_ready = 1, no mem_wr_en pulse, and memory word unchanged.
